ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding icache request engine with a
// one-entry instruction buffer toward decode and redirect/discard handling.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ic_valid,
  output logic [22:0] ic_tag,
  output logic [5:0]  ic_index,
  output logic [2:0]  ic_offset,
  input  logic        ic_addr_ok,
  input  logic        ic_data_ok,
  input  logic [31:0] ic_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] inst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [63:0] inst_cnt_q, inst_cnt_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  // Redirect targets are word aligned; the low two bits are forced to zero.
  logic [63:0] redirect_target;
  assign redirect_target = redirect_pc & ~64'h3;

  // Next-state, pc, discard and buffer logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    inst_cnt_d = inst_cnt_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redirect_target;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          // An accepted request whose pc was just replaced returns stale data.
          if (ic_addr_ok) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (ic_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ic_data_ok) begin
          if (redirect_valid) begin
            pc_d      = redirect_target;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            if_inst_d = ic_rdata;
            if_pc_d   = pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d      = redirect_target;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect wins over a same-cycle handshake: the buffered word is dropped.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d       = pc_q + 64'd4;
          inst_cnt_d = inst_cnt_q + 64'd1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      inst_cnt_q <= 64'd0;
      if_pc_q    <= 64'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      inst_cnt_q <= inst_cnt_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign ic_valid  = (state_q == S_REQ);
  assign ic_tag    = pc_q[31:9];
  assign ic_index  = pc_q[8:3];
  assign ic_offset = pc_q[2:0];
  assign if_valid  = (state_q == S_HOLD);
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign inst_cnt  = inst_cnt_q;

endmodule
